// File: rtl/dmem_if.sv
// Load/store request and response channels between the core MEM stage and
// the data-memory responder.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency doubleword data memory for the core's load/store port.
// One request outstanding; misaligned or out-of-range accesses return an error.
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic  clock,
   input  logic  reset_n,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   logic          we_q;
   logic [63:0]   addr_q;
   logic [63:0]   wdata_q;
   logic [7:0]    wstrb_q;
   logic [63:0]   rdata_q;
   logic          err_q;

   logic [63:0]   mem [DEPTH];

   logic          accept;
   logic          commit;
   logic          handshake;
   logic          acc_err;
   logic [AW-1:0] idx;

   assign accept    = bus.req_valid && (state == IDLE);
   assign commit    = (state == WAIT) && (cnt == '0);
   assign handshake = (state == RESP) && bus.resp_ready;
   assign acc_err   = (addr_q[2:0] != 3'd0) || (addr_q[63:3] >= 61'(DEPTH));
   assign idx       = addr_q[3 +: AW];

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // LATENCY==1 loads the counter with 0, so WAIT commits on the very next edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = WAIT;
               cnt_nxt   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - 1'b1;
         end
         RESP: begin
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         wstrb_q <= bus.req_wstrb;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         rdata_q <= (!acc_err && !we_q) ? mem[idx] : 64'd0;
         err_q   <= acc_err;
      end else if (handshake) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end
   end

   // Array is deliberately unreset; commit is gated by the reset state machine.
   always_ff @(posedge clock) begin
      if (commit && we_q && !acc_err) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It services the core's load/store requests over a valid/ready request channel and a valid/ready response channel, against a doubleword-wide memory array. Each access has a fixed, parameterised latency, so the core's MEM stage can be exercised against slow memory. Exactly one request is outstanding at a time; misaligned and out-of-range addresses return an error response.

## Interface
- `DEPTH`, 1024, number of 64-bit doublewords in the array; power of two, ≥2.
- `LATENCY`, 2, cycles from request acceptance to `resp_valid`; integer ≥1.

- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = store (SD), 0 = load (LD).
- `req_addr` input 64: byte address.
- `req_wdata` input 64: store data.
- `req_wstrb` input 8: byte-write enables for stores; bit i covers `wdata[8i+7:8i]`. Ignored for loads.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: core accepts the response.
- `resp_rdata` output 64: load data; 0 for stores and errors.
- `resp_err` output 1: access was misaligned or out of range.

## Operation
- **States**
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown.
  - RESP: `resp_valid`=1.
- **Accept**
  - Acceptance is `req_valid && req_ready` at a rising edge.
  - On accept, latch we/addr/wdata/wstrb and load the counter with `LATENCY-1`.
  - Go to WAIT if `LATENCY>1`; go directly to the commit step if `LATENCY==1`.
- **WAIT**
  - Decrement the counter each cycle.
  - At the edge where the counter is 0, commit and go to RESP.
- **Commit**
  - Error condition: error if `addr[2:0]!=0` or `addr[63:3] >= DEPTH`.
  - On error: no array access, `resp_err`=1, `resp_rdata`=0.
  - Otherwise the index is `addr[3+:log2(DEPTH)]`.
  - Load: `resp_rdata` = `mem[index]`.
  - Store: write only the bytes enabled in `wstrb`, then `resp_rdata`=0. A store with `wstrb`=0 is legal: no bytes change and a normal response is returned.
- **RESP**
  - `resp_valid`, `resp_rdata` and `resp_err` stay stable until `resp_ready` is sampled high.
  - Then go to IDLE.
  - A request cannot be accepted in the same cycle as a response handshake.
- **Inputs outside IDLE:** `req_*` inputs are ignored while not in IDLE. A request held through WAIT/RESP is accepted in the first IDLE cycle.
- **Array:** contents are not reset and are undefined at power-up. They are preserved across `reset_n` assertion, except as stated under Timing.
- **Ordering:** a load following a store to the same doubleword returns the merged store data, because only one request is outstanding.

## Timing
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state=IDLE, counter=0.
- **Reset mid-operation:** `reset_n` low in WAIT aborts the request immediately; no array write occurs. `reset_n` low in RESP drops the response; a store already committed stays committed.
- **Latency:** acceptance at edge N gives `resp_valid` high after edge N+LATENCY.
- **Throughput:** with `resp_ready` tied high, at most one request per LATENCY+2 cycles (accept, LATENCY cycles, return to IDLE).
- **Registered outputs:** `req_ready` is registered (state==IDLE); it drops the cycle after acceptance. `resp_valid`, `resp_rdata` and `resp_err` are registered. No combinational path from any input to any output.
- **Backpressure:** `resp_ready` low extends RESP indefinitely with outputs held.

## Test plan
1. Reset, then store addr 0x10, data 0x1122334455667788, wstrb 0xFF. Next, load addr 0x10 with LATENCY=2, `resp_ready`=1. Required: `resp_valid` exactly 2 edges after each accept; load returns 0x1122334455667788 with `resp_err`=0; the store response has rdata 0.
2. Byte-mask store to addr 0x10, data 0xAAAAAAAAAAAAAAAA, wstrb 0x0F, then load. Required: 0x11223344AAAAAAAA.
3. Misaligned load addr 0x14, then a store to addr `8*DEPTH` (0x2000). Required: `resp_err`=1 and rdata 0 for both; a reload of 0x10 is unchanged.
4. Hold `resp_ready`=0 for 5 cycles in RESP with `req_valid` continuously high. Required: `resp_valid`/`rdata` stable, `req_ready`=0 throughout; the new request is accepted on the first IDLE edge after the handshake.
5. Store to 0x18 with value 0xDEAD; assert `reset_n` low 1 cycle after accept (WAIT, LATENCY=3). Required: outputs return to reset values asynchronously; a subsequent load of 0x18 returns the prior contents, not 0xDEAD.
6. LATENCY=1 build: back-to-back loads with `resp_ready`=1. Required: `resp_valid` 1 edge after accept; accepts spaced 3 cycles apart.
